// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ============================================================================
// pipe_adder_pkg : shared defaults and stage-count helper for pipe_adder
// Revision 1.0
// ============================================================================
package pipe_adder_pkg;

    localparam int unsigned c_DEF_WIDTH = 32;
    localparam int unsigned c_DEF_SEG_W = 8;

    function automatic int unsigned calc_nseg(input int unsigned width,
                                              input int unsigned seg_w);
        return width / seg_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_seg_stage.sv
`default_nettype none
// ============================================================================
// add_seg_stage : one SEG_W-bit ripple segment with registered sum/carry/valid
// Revision 1.0
// ============================================================================
module add_seg_stage #(
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [SEG_W-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [SEG_W:0]   w_raw;
    logic             w_valid_d, w_carry_d, w_ovf_d;
    logic [SEG_W-1:0] w_sum_d;
    logic             r_valid_q, r_carry_q, r_ovf_q;
    logic [SEG_W-1:0] r_sum_q;

    // Bubbles carry all-zero data so idle operand buses never reach the outputs.
    always_comb begin
        w_raw     = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, carry_i};
        w_valid_d = valid_i;
        w_sum_d   = '0;
        w_carry_d = 1'b0;
        w_ovf_d   = 1'b0;
        if (valid_i) begin
            w_sum_d   = w_raw[SEG_W-1:0];
            w_carry_d = w_raw[SEG_W];
            w_ovf_d   = (a_i[SEG_W-1] ^ b_i[SEG_W-1] ^ w_raw[SEG_W-1]) ^ w_raw[SEG_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else if (adv_i) begin
            r_valid_q <= w_valid_d;
            r_sum_q   <= w_sum_d;
            r_carry_q <= w_carry_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign valid_o = r_valid_q;
    assign sum_o   = r_sum_q;
    assign carry_o = r_carry_q;
    assign ovf_o   = r_ovf_q;

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// pipe_adder : segmented pipelined add/subtract with ready/valid handshake
// Revision 1.0
// ============================================================================
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEF_WIDTH,
    parameter int unsigned SEG_W = c_DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned c_NSEG = calc_nseg(WIDTH, SEG_W);

    generate
        if ((WIDTH % SEG_W) != 0) begin : g_bad_split
            $error("pipe_adder: WIDTH must be an integer multiple of SEG_W");
        end
    endgenerate

    logic              w_adv;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_ci_eff;
    logic [WIDTH-1:0]  w_opa   [c_NSEG];
    logic [WIDTH-1:0]  w_opb   [c_NSEG];
    logic [WIDTH-1:0]  r_opa_q [c_NSEG];
    logic [WIDTH-1:0]  r_opb_q [c_NSEG];
    logic [WIDTH-1:0]  r_low_q [c_NSEG];
    logic [WIDTH-1:0]  w_res   [c_NSEG];
    logic [SEG_W-1:0]  w_seg   [c_NSEG];
    logic [c_NSEG-1:0] w_vld, w_cry, w_ovf;
    logic              w_unused;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_ci_eff = ci ^ sub;

    generate
        for (genvar k = 0; k < int'(c_NSEG); k++) begin : g_stage
            logic w_vin, w_cin;

            if (k == 0) begin : g_first
                assign w_opa[k] = a;
                assign w_opb[k] = w_b_eff;
                assign w_vin    = in_valid;
                assign w_cin    = w_ci_eff;
            end else begin : g_next
                assign w_opa[k] = r_opa_q[k-1];
                assign w_opb[k] = r_opb_q[k-1];
                assign w_vin    = w_vld[k-1];
                assign w_cin    = w_cry[k-1];
            end

            add_seg_stage #(
                .SEG_W (SEG_W)
            ) u_seg (
                .clk     (clk),
                .rst     (rst),
                .adv_i   (w_adv),
                .valid_i (w_vin),
                .a_i     (w_opa[k][k*SEG_W +: SEG_W]),
                .b_i     (w_opb[k][k*SEG_W +: SEG_W]),
                .carry_i (w_cin),
                .valid_o (w_vld[k]),
                .sum_o   (w_seg[k]),
                .carry_o (w_cry[k]),
                .ovf_o   (w_ovf[k])
            );

            // r_low_q[k] only ever holds bits below segment k, so OR merges cleanly.
            assign w_res[k] = r_low_q[k] | (WIDTH'(w_seg[k]) << (k*SEG_W));
        end
    endgenerate

    // Operand skew chain and result de-skew chain, advancing in lockstep with the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(c_NSEG); k++) begin
                r_opa_q[k] <= '0;
                r_opb_q[k] <= '0;
                r_low_q[k] <= '0;
            end
        end else if (w_adv) begin
            r_low_q[0] <= '0;
            for (int k = 0; k < int'(c_NSEG); k++) begin
                r_opa_q[k] <= w_opa[k];
                r_opb_q[k] <= w_opb[k];
            end
            for (int k = 1; k < int'(c_NSEG); k++) begin
                r_low_q[k] <= w_res[k-1];
            end
        end
    end

    assign out_valid = w_vld[c_NSEG-1];
    assign sum       = w_res[c_NSEG-1];
    assign co        = w_cry[c_NSEG-1];
    assign ovf       = w_ovf[c_NSEG-1];

    // The last skew stage and the inner-segment overflow flags have no consumer.
    assign w_unused = ^{r_opa_q[c_NSEG-1], r_opb_q[c_NSEG-1], w_ovf};

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pipe_adder : directed and randomized checks of pipe_adder in three shapes
// Revision 1.0
// ============================================================================
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        ci, sub;

    logic        vi32, ir32, ov32, or32, co32, of32;
    logic [31:0] s32;
    logic        vi8, ir8, ov8, or8, co8, of8;
    logic [7:0]  s8;
    logic        vi16, ir16, ov16, or16, co16, of16;
    logic [15:0] s16;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(32), .SEG_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(vi32), .in_ready(ir32), .a(a), .b(b),
        .ci(ci), .sub(sub), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .co(co32), .ovf(of32));

    pipe_adder #(.WIDTH(8), .SEG_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(vi8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
        .ci(ci), .sub(sub), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .co(co8), .ovf(of8));

    pipe_adder #(.WIDTH(16), .SEG_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(vi16), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]),
        .ci(ci), .sub(sub), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .co(co16), .ovf(of16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, co, sum} of a +/- b +/- ci at width w (w <= 32).
    function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [63:0] m, be, full, r;
        logic        sa, sb, sr;
        m    = (64'd1 << w) - 64'd1;
        be   = (s ? ~{32'd0, y} : {32'd0, y}) & m;
        full = ({32'd0, x} & m) + be + {63'd0, c ^ s};
        r    = full & m;
        sa   = x[w-1];
        sb   = be[w-1];
        sr   = r[w-1];
        return {(sa == sb) && (sr != sa), full[w], r[31:0]};
    endfunction

    task automatic op32(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xc, input logic xs,
                        input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        @(negedge clk);
        a = xa; b = xb; ci = xc; sub = xs; vi32 = 1'b1; or32 = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            vi32 = 1'b0;
            lat++;
        end while (!ov32 && lat < 20);
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, s32, es);
        check({tag, " co"}, co32, eco);
        check({tag, " ovf"}, of32, eov);
    endtask

    logic [33:0] q32[$], q8[$], q16[$];
    logic [33:0] held;
    logic        stalled;
    int          issued, got, cyc, seen, lat8, lat16, acc8, acc16, got8, got16;

    initial begin
        rst = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        vi32 = 1'b0; or32 = 1'b1; vi8 = 1'b0; or8 = 1'b1; vi16 = 1'b0; or16 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out_valid", ov32, 64'd0);
        check("reset sum", s32, 64'd0);
        check("reset co", co32, 64'd0);
        check("reset ovf", of32, 64'd0);
        check("reset in_ready", ir32, 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", ir32, 64'd1);

        op32("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        op32("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        op32("neg_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        op32("sub_5_7",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op32("sub_bin",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        op32("min_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        op32("seg_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
        op32("add_ci",    32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0);

        // Eight back-to-back issues with out_ready toggling 1,0,1,0...
        issued = 0; got = 0; stalled = 1'b0; cyc = 0; held = '0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stalled) check("b2b hold", {ov32, of32, co32, s32}, {1'b1, held});
            or32 = (cyc % 2) == 1;
            if (issued < 8) begin
                vi32 = 1'b1;
                a    = 32'h9E37_79B9 * 32'(issued + 1);
                b    = 32'h7F4A_7C15 ^ (a << 3);
                ci   = 1'(issued);
                sub  = 1'(issued >> 1);
            end else begin
                vi32 = 1'b0;
            end
            #1;
            stalled = ov32 && !or32;
            if (stalled) held = {of32, co32, s32};
            if (ov32 && or32) begin
                if (q32.size() > 0) check("b2b result", {of32, co32, s32}, q32.pop_front());
                else                check("b2b spurious", ov32, 64'd0);
                got++;
            end
            if (vi32 && ir32) begin
                q32.push_back(model(32, a, b, ci, sub));
                issued++;
            end
        end
        vi32 = 1'b0;
        check("b2b received", 64'(got), 64'd8);
        check("b2b issued", 64'(issued), 64'd8);

        // Fill the pipe with out_ready low, then reset while a result is held.
        @(negedge clk);
        or32 = 1'b0; vi32 = 1'b1; a = 32'd1; b = 32'd2; ci = 1'b0; sub = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vi32 = 1'b0;
        check("flush setup out_valid", ov32, 64'd1);
        rst = 1'b1;
        #1;
        check("async rst out_valid", ov32, 64'd0);
        check("async rst sum", s32, 64'd0);
        check("async rst in_ready", ir32, 64'd1);
        @(negedge clk);
        rst = 1'b0; or32 = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        check("no stale after reset", 64'(seen), 64'd0);
        check("in_ready after reset", ir32, 64'd1);

        // Latency of the 8/8 and 16/4 shapes.
        @(negedge clk);
        a = 32'h0000_00F7; b = 32'h0000_001C; ci = 1'b1; sub = 1'b0;
        vi8 = 1'b1; vi16 = 1'b1; or8 = 1'b1; or16 = 1'b1;
        @(posedge clk);
        lat8 = 0; lat16 = 0; cyc = 0;
        while ((lat8 == 0 || lat16 == 0) && cyc < 20) begin
            @(negedge clk);
            vi8 = 1'b0; vi16 = 1'b0;
            cyc++;
            if (ov8 && lat8 == 0) begin
                lat8 = cyc;
                check("w8 sum", s8, 64'h14);
                check("w8 co", co8, 64'd1);
            end
            if (ov16 && lat16 == 0) begin
                lat16 = cyc;
                check("w16 sum", s16, 64'h0114);
                check("w16 co", co16, 64'd0);
            end
        end
        check("w8 latency", 64'(lat8), 64'd1);
        check("w16 latency", 64'(lat16), 64'd4);

        // 1000 random operations each with random bubbles and backpressure.
        acc8 = 0; acc16 = 0; got8 = 0; got16 = 0; cyc = 0;
        while ((got8 < 1000 || got16 < 1000) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            a    = $urandom;
            b    = $urandom;
            ci   = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            vi8  = (acc8 < 1000) && ($urandom_range(0, 3) != 0);
            vi16 = (acc16 < 1000) && ($urandom_range(0, 3) != 0);
            or8  = $urandom_range(0, 3) != 0;
            or16 = $urandom_range(0, 3) != 0;
            #1;
            if (ov8 && or8) begin
                if (q8.size() > 0) check("rnd w8", {of8, co8, 24'd0, s8}, q8.pop_front());
                else               check("rnd w8 spurious", ov8, 64'd0);
                got8++;
            end
            if (ov16 && or16) begin
                if (q16.size() > 0) check("rnd w16", {of16, co16, 16'd0, s16}, q16.pop_front());
                else                check("rnd w16 spurious", ov16, 64'd0);
                got16++;
            end
            if (vi8 && ir8) begin
                q8.push_back(model(8, a, b, ci, sub));
                acc8++;
            end
            if (vi16 && ir16) begin
                q16.push_back(model(16, a, b, ci, sub));
                acc16++;
            end
        end
        vi8 = 1'b0; vi16 = 1'b0;
        check("rnd w8 count", 64'(got8), 64'd1000);
        check("rnd w16 count", 64'(got16), 64'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SEG_W, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG_W (elaboration error otherwise).
REQ-003 Derived constant NSEG = WIDTH/SEG_W: number of pipeline stages and the latency in cycles.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand set presented.
REQ-007 in_ready  out  1  block can accept an operand set this cycle.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 ci  in  1  carry-in (add) or borrow-in (sub).
REQ-011 sub  in  1  0 = add, 1 = subtract.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 sum  out  WIDTH  result modulo 2^WIDTH.
REQ-015 co  out  1  carry out of bit WIDTH-1.
REQ-016 ovf  out  1  two's-complement signed overflow.

Function
REQ-017 Acceptance SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-018 Pipeline advance SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv, and all stages SHALL shift together only when adv=1.
REQ-019 Effective operands SHALL be b_eff = sub ? ~b : b and ci_eff = ci ^ sub, giving a+b+ci in add mode and a-b-ci in sub mode.
REQ-020 Stage k (0..NSEG-1) SHALL add segment k of a and b_eff plus the carry registered by stage k-1 (stage 0 uses ci_eff); upper segments SHALL be skew-delayed and lower result segments de-skew-delayed so that all segments of one result emerge together.
REQ-021 With no stall, a result SHALL appear on out_valid exactly NSEG cycles after acceptance; sustained throughput SHALL be one result per cycle.
REQ-022 co SHALL be the raw final carry (in sub mode co=1 means no borrow); ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-023 While out_valid=1 and out_ready=0, sum, co, ovf and all internal stages SHALL hold unchanged.
REQ-024 Results SHALL leave in acceptance order with no loss or duplication; bubbles SHALL propagate as invalid slots.
REQ-025 NSEG=1 SHALL degenerate to a single registered adder with latency 1.
REQ-026 Inputs other than in_valid are don't-care when in_valid=0 and SHALL NOT affect outputs.

Reset
REQ-027 While rst=1: all stage valid flags, carries, out_valid, sum, co and ovf SHALL be 0, independent of clk.
REQ-028 in_ready SHALL read 1 during and immediately after reset.
REQ-029 Assertion of rst mid-operation SHALL discard all in-flight operations; none SHALL appear after release.

Structure
REQ-030 Shared package pipe_adder_pkg SHALL hold default WIDTH, default SEG_W and a function computing NSEG.
REQ-031 Sub-module add_seg_stage SHALL implement one SEG_W-bit segment add with registered carry and valid, enabled by adv, instantiated NSEG times in a generate loop.

Verification (WIDTH=32, SEG_W=8 unless stated)
REQ-032 a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 -> sum=0x00000000, co=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 a=0x7FFFFFFF, b=1, add -> sum=0x80000000, co=0, ovf=1; a=0x80000000, b=1, sub, ci=0 -> sum=0x7FFFFFFF, co=1, ovf=1.
REQ-034 a=5, b=7, sub, ci=0 -> sum=0xFFFFFFFE, co=0, ovf=0; same with ci=1 -> sum=0xFFFFFFFD.
REQ-035 8 back-to-back accepts, out_ready toggling 1,0,1,0 -> all 8 results in order, none lost or duplicated, outputs stable on every stalled cycle.
REQ-036 3 ops in flight, rst pulsed 1 cycle -> out_valid=0 from the reset assertion onward, no stale result after release, in_ready=1.
REQ-037 WIDTH=8/SEG_W=8 and WIDTH=16/SEG_W=4 with 1000 random ops each and random backpressure -> matches reference model; latency 1 and 4 respectively.
